// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared states, port indices and bus widths for bus_arbiter
package bus_arbiter_pkg;
  localparam int REG_BUS_W       = 32;  // RegBus
  localparam int INST_ADDR_BUS_W = 32;  // InstAddrBus

  localparam logic       PORT_IF     = 1'b0;
  localparam logic       PORT_MEM    = 1'b1;
  localparam logic [3:0] BUS_SEL_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS_IF,
    ST_BUS_MEM,
    ST_DONE
  } arb_state_e;
endpackage

// File: rtl/bus_arb_pick.sv
// rtl/bus_arb_pick.sv - IF/MEM grant selection with a saturating IF starvation counter
module bus_arb_pick
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic mem_req,
  input  logic grant_if,
  input  logic grant_mem,
  output logic grant_any,
  output logic grant_idx
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant_any = if_req | mem_req;
    grant_idx = PORT_IF;
    // MEM normally wins, unless IF has been passed over STARVE_MAX times in a row
    if (mem_req && (!if_req || starve_cnt_q < STARVE_LIM)) begin
      grant_idx = PORT_MEM;
    end

    starve_cnt_d = starve_cnt_q;
    if (grant_if) begin
      starve_cnt_d = '0;
    end else if (grant_mem && if_req && starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one strobe/ack memory bus between the IF and MEM ports
// Optional bus_ack timeout with bus_err pulse: define BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_BUS_W,
  parameter int DATA_W     = REG_BUS_W,
  parameter int STARVE_MAX = 4
`ifdef BUS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [1:0]        stall_o,
  output logic              bus_err
);
  arb_state_e        state_q, state_d;
  logic              bus_stb_q, bus_stb_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              grant_any, grant_idx, grant_if, grant_mem;
  logic              cyc_done;
  logic [DATA_W-1:0] cyc_rdata;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          bus_err_q, bus_err_d;
`endif

  bus_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .mem_req   (mem_req),
    .grant_if  (grant_if),
    .grant_mem (grant_mem),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    bus_stb_d   = bus_stb_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    cyc_done    = 1'b0;
    cyc_rdata   = bus_rdata;
`ifdef BUS_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          bus_stb_d = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (grant_idx == PORT_MEM) begin
            grant_mem   = 1'b1;
            state_d     = ST_BUS_MEM;
            bus_we_d    = mem_we;
            bus_addr_d  = mem_addr;
            bus_sel_d   = mem_sel;
            bus_wdata_d = mem_wdata;
          end else begin
            grant_if    = 1'b1;
            state_d     = ST_BUS_IF;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr;
            bus_sel_d   = BUS_SEL_ALL;
            bus_wdata_d = '0;
          end
        end
      end
      ST_BUS_IF, ST_BUS_MEM: begin
        if (bus_ack) begin
          cyc_done = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          cyc_done  = 1'b1;
          cyc_rdata = '0;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
        // a requester that dropped req (flush) still gets rdata but no ack pulse
        if (cyc_done) begin
          bus_stb_d = 1'b0;
          state_d   = ST_DONE;
          if (state_q == ST_BUS_IF) begin
            if_rdata_d = cyc_rdata;
            if_ack_d   = if_req;
          end else begin
            mem_rdata_d = cyc_rdata;
            mem_ack_d   = mem_req;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_stb_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_stb_q   <= bus_stb_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign bus_stb   = bus_stb_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  // stalls are gated by rst so that every output reads 0 while reset is held
  assign stall_o   = {mem_req & ~mem_ack_q, if_req & ~if_ack_q} & {2{rst}};
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - vector table plus scoreboard bench for bus_arbiter
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, mem_req, mem_we, mem_ack;
  logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel, bus_sel;
  logic        bus_stb, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  stall_o;

  int total = 0;
  int bad   = 0;
  int slv_waits = 0;
  logic slv_never = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          len;
  } bus_exp_t;
  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;
  typedef struct {
    string       name;
    logic        if_en;
    logic [31:0] if_a;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wd;
    int          waits;
    logic        mem_first;
  } vec_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];
  vec_t     vecs[6];

  initial forever #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
`ifdef BUS_ARB_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_o(stall_o), .bus_err(bus_err)
  );

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a ^ 32'h3C010001;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void push_bus(input logic we, input logic [31:0] a, input logic [3:0] sel,
                                   input logic [31:0] wd, input int len);
    bus_exp_t e;
    e.we = we; e.addr = a; e.sel = sel; e.wdata = wd; e.len = len;
    bus_q.push_back(e);
  endfunction

  function automatic void push_ack(input logic port, input logic [31:0] rd, input logic err);
    ack_exp_t e;
    e.port = port; e.rdata = rd; e.err = err;
    ack_q.push_back(e);
  endfunction

  // passive bus monitor, scoreboard consumer and slave model in one process
  task automatic monitor();
    logic        in_stb = 1'b0;
    int          len = 0, low = 10, wcnt = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata, rd;
    logic [3:0]  h_sel;
    bus_exp_t    e;
    ack_exp_t    a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_stb && bus_q.size() > 0) void'(bus_q.pop_front());
        in_stb = 1'b0;
        low = 10;
      end else if (bus_stb) begin
        if (!in_stb) begin
          check("stb_gap", low >= 2, 1'b1);
          check("bus_expected", bus_q.size() > 0, 1'b1);
          in_stb = 1'b1; len = 1;
          h_we = bus_we; h_addr = bus_addr; h_sel = bus_sel; h_wdata = bus_wdata;
        end else begin
          len++;
          check("bus_hold", {bus_we, bus_addr, bus_sel, bus_wdata}, {h_we, h_addr, h_sel, h_wdata});
        end
      end else if (in_stb) begin
        in_stb = 1'b0; low = 1;
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          check("bus_txn", {h_we, h_addr, h_sel, (h_we ? h_wdata : 32'h0), len[15:0]},
                {e.we, e.addr, e.sel, (e.we ? e.wdata : 32'h0), e.len[15:0]});
        end
      end else begin
        low++;
      end

      if (if_ack || mem_ack) begin
        check("ack_expected", ack_q.size() > 0, 1'b1);
        if (ack_q.size() > 0) begin
          a = ack_q.pop_front();
          rd = if_ack ? if_rdata : mem_rdata;
          check("ack", {if_ack, mem_ack, rd, bus_err}, {a.port == 1'b0, a.port == 1'b1, a.rdata, a.err});
        end
      end else if (bus_err) begin
        check("bus_err_alone", bus_err, 1'b0);
      end

      if (bus_stb && !bus_ack && !slv_never) begin
        if (wcnt == slv_waits) begin
          bus_ack = 1'b1; bus_rdata = slave_data(bus_addr); wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        bus_ack = 1'b0;
        if (!bus_stb) wcnt = 0;
      end
    end
  endtask

  task automatic if_txn(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (if_ack) break;
    end
    check("if_ack_seen", if_ack, 1'b1);
    if_req = 1'b0;
  endtask

  task automatic mem_txn(input logic we, input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_sel = sel; mem_wdata = wd;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (mem_ack) break;
    end
    check("mem_ack_seen", mem_ack, 1'b1);
    mem_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    slv_waits = v.waits;
    if (v.mem_en && v.mem_first) begin
      push_bus(v.mem_we, v.mem_a, v.mem_sel, v.mem_wd, v.waits + 1);
      push_ack(1'b1, slave_data(v.mem_a), 1'b0);
    end
    if (v.if_en) begin
      push_bus(1'b0, v.if_a, 4'hF, 32'h0, v.waits + 1);
      push_ack(1'b0, slave_data(v.if_a), 1'b0);
    end
    if (v.mem_en && !v.mem_first) begin
      push_bus(v.mem_we, v.mem_a, v.mem_sel, v.mem_wd, v.waits + 1);
      push_ack(1'b1, slave_data(v.mem_a), 1'b0);
    end
    fork
      begin if (v.if_en) if_txn(v.if_a); end
      begin if (v.mem_en) mem_txn(v.mem_we, v.mem_a, v.mem_sel, v.mem_wd); end
    join
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"if_only",    1'b1, 32'h200, 1'b0, 1'b0, 32'h0,    4'h0,    32'h0,        0, 1'b0};
    vecs[1] = '{"both_wr",    1'b1, 32'h204, 1'b1, 1'b1, 32'h2000, 4'b0011, 32'hDEADBEEF, 0, 1'b1};
    vecs[2] = '{"mem_wait3",  1'b0, 32'h0,   1'b1, 1'b0, 32'h40,   4'hF,    32'h0,        3, 1'b1};
    vecs[3] = '{"both_rd_w2", 1'b1, 32'h208, 1'b1, 1'b0, 32'h44,   4'b1100, 32'h0,        2, 1'b1};
    vecs[4] = '{"if_wait1",   1'b1, 32'h20C, 1'b0, 1'b0, 32'h0,    4'h0,    32'h0,        1, 1'b0};
    vecs[5] = '{"mem_wr_w1",  1'b0, 32'h0,   1'b1, 1'b1, 32'h48,   4'b0001, 32'h12345678, 1, 1'b1};

    rst = 1'b0; if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #2;
    check("reset_outputs", {if_rdata, if_ack, mem_rdata, mem_ack, bus_stb, bus_we, bus_addr,
                            bus_sel, bus_wdata, stall_o, bus_err}, 160'h0);
    if_req = 1'b0; mem_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    fork monitor(); join_none
    @(negedge clk);

    // single fetch with exact cycle-by-cycle latency
    push_bus(1'b0, 32'h100, 4'hF, 32'h0, 1);
    push_ack(1'b0, 32'h3C010101, 1'b0);
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    check("t1_n_stall", {stall_o, bus_stb}, {2'b01, 1'b0});
    @(negedge clk);
    check("t1_n1_bus", {bus_stb, bus_we, bus_addr, bus_sel, stall_o}, {1'b1, 1'b0, 32'h100, 4'hF, 2'b01});
    @(negedge clk);
    check("t1_n2_ack", {if_ack, if_rdata, stall_o}, {1'b1, 32'h3C010101, 2'b00});
    if_req = 1'b0;
    @(negedge clk);
    check("t1_n3_stb", bus_stb, 1'b0);
    repeat (2) @(negedge clk);

    // MEM held busy while IF waits: four MEM grants, then IF, then MEM again
    slv_waits = 0;
    for (int k = 0; k < 4; k++) begin
      push_bus(1'b0, 32'h3000 + 32'(k * 4), 4'hF, 32'h0, 1);
      push_ack(1'b1, slave_data(32'h3000 + 32'(k * 4)), 1'b0);
    end
    push_bus(1'b0, 32'h400, 4'hF, 32'h0, 1);
    push_ack(1'b0, slave_data(32'h400), 1'b0);
    push_bus(1'b0, 32'h3010, 4'hF, 32'h0, 1);
    push_ack(1'b1, slave_data(32'h3010), 1'b0);
    fork
      if_txn(32'h400);
      begin
        for (int k = 0; k < 5; k++) mem_txn(1'b0, 32'h3000 + 32'(k * 4), 4'hF, 32'h0);
      end
    join
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset in the middle of a MEM bus cycle
    slv_waits = 10;
    push_bus(1'b1, 32'h80, 4'hF, 32'hA5A5A5A5, 11);
    push_ack(1'b1, slave_data(32'h80), 1'b0);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_sel = 4'hF; mem_wdata = 32'hA5A5A5A5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_stb) break;
    end
    check("t5_stb_up", bus_stb, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_reset_outputs", {if_rdata, if_ack, mem_rdata, mem_ack, bus_stb, bus_we, bus_addr,
                               bus_sel, bus_wdata, stall_o, bus_err}, 160'h0);
    mem_req = 1'b0;
    ack_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    slv_waits = 0;
    repeat (2) @(negedge clk);
    run_vec(vecs[0]);

    // fetch flushed while its bus cycle is in flight
    slv_waits = 2;
    push_bus(1'b0, 32'h500, 4'hF, 32'h0, 3);
    if_req = 1'b1; if_addr = 32'h500;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_stb) break;
    end
    if_req = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_rdata", if_rdata, slave_data(32'h500));

`ifdef BUS_ARB_TIMEOUT_EN
    slv_never = 1'b1;
    push_bus(1'b0, 32'h600, 4'hF, 32'h0, 8);
    push_ack(1'b0, 32'h0, 1'b1);
    if_txn(32'h600);
    slv_never = 1'b0;
    @(negedge clk);
    check("tmo_stb_low", bus_stb, 1'b0);
    repeat (2) @(negedge clk);
`endif

    check("bus_q_drained", bus_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
